// File: rtl/esc_pwm_out.sv
// esc_pwm_out: 4-channel ESC servo-PWM generator with arm/disarm FSM.
// Define ESC_WATCHDOG_EN to add the command-loss watchdog.
module esc_pwm_out #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int FRAME_US   = 2500,
   parameter int MIN_US     = 1000,
   parameter int MAX_US     = 2000,
   parameter int ARM_FRAMES = 200,
   parameter int WDT_FRAMES = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        arm,
   input  logic        cmd_valid,
   input  logic [15:0] m1,
   input  logic [15:0] m2,
   input  logic [15:0] m3,
   input  logic [15:0] m4,
   output logic [3:0]  pwm,
   output logic        frame_start,
   output logic        armed,
   output logic [3:0]  sat,
   output logic        wdt_trip
);

   localparam int DIV   = CLK_HZ / 1_000_000;
   localparam int RANGE = MAX_US - MIN_US;
   localparam int DW    = $clog2(DIV);
   localparam int UW    = $clog2(FRAME_US);
   localparam int AW    = $clog2(ARM_FRAMES + 1);

   localparam logic signed [15:0] RNG  = 16'(RANGE);
   localparam logic signed [15:0] ZERO = 16'sd0;
   localparam logic [DW-1:0] DIV_TOP = DW'(DIV - 1);
   localparam logic [DW-1:0] DIV_ONE = DW'(1);
   localparam logic [UW-1:0] US_TOP  = UW'(FRAME_US - 1);
   localparam logic [UW-1:0] US_ONE  = UW'(1);
   localparam logic [UW-1:0] US_MIN  = UW'(MIN_US);
   localparam logic [AW-1:0] ARM_TOP = AW'(ARM_FRAMES - 1);
   localparam logic [AW-1:0] ARM_ONE = AW'(1);

   typedef enum logic [1:0] {
      DISARMED,
      ARMING,
      ARMED
   } state_t;

   state_t state;
   state_t state_nx;

   logic [DW-1:0] div_cnt;
   logic [UW-1:0] us_cnt;
   logic [AW-1:0] arm_cnt;
   logic          tick;
   logic          bnd;
   logic          trip_now;

   logic signed [15:0] mv [4];
   logic [UW-1:0]      cv [4];
   logic [3:0]         sv;
   logic [UW-1:0]      shadow [4];
   logic [UW-1:0]      width [4];

   assign tick  = (div_cnt == DIV_TOP);
   assign bnd   = tick && (us_cnt == US_TOP);
   assign armed = (state == ARMED);

   always_comb begin
      mv[0] = m1;
      mv[1] = m2;
      mv[2] = m3;
      mv[3] = m4;
   end

   // Signed clamp into 0..RANGE; the flag marks any clipped channel.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cv[i] = UW'(mv[i]);
         sv[i] = 1'b0;
         if (mv[i] < ZERO) begin
            cv[i] = '0;
            sv[i] = 1'b1;
         end else if (mv[i] > RNG) begin
            cv[i] = UW'(RNG);
            sv[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt     <= '0;
         us_cnt      <= US_TOP;
         frame_start <= 1'b0;
         pwm         <= '0;
         sat         <= '0;
         for (int i = 0; i < 4; i++) begin
            shadow[i] <= '0;
            width[i]  <= US_MIN;
         end
      end else begin
         div_cnt     <= tick ? '0 : div_cnt + DIV_ONE;
         frame_start <= bnd;
         if (tick)
            us_cnt <= (us_cnt == US_TOP) ? '0 : us_cnt + US_ONE;
         if (cmd_valid)
            sat <= sv;
         // Widths latch only at the frame boundary, so pulses never glitch.
         for (int i = 0; i < 4; i++) begin
            if (bnd)
               width[i] <= armed ? US_MIN + shadow[i] : US_MIN;
            if (cmd_valid)
               shadow[i] <= cv[i];
            pwm[i] <= (us_cnt < width[i]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= DISARMED;
         arm_cnt <= '0;
      end else begin
         state <= state_nx;
         if (state != ARMING)
            arm_cnt <= '0;
         else if (bnd)
            arm_cnt <= arm_cnt + ARM_ONE;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         DISARMED: begin
            if (arm && !wdt_trip)
               state_nx = ARMING;
         end
         ARMING: begin
            if (!arm)
               state_nx = DISARMED;
            else if (bnd && arm_cnt == ARM_TOP)
               state_nx = ARMED;
         end
         ARMED: begin
            if (!arm || trip_now)
               state_nx = DISARMED;
         end
         default: state_nx = DISARMED;
      endcase
   end

`ifdef ESC_WATCHDOG_EN
   localparam int WW = $clog2(WDT_FRAMES + 1);
   localparam logic [WW-1:0] WDT_TOP = WW'(WDT_FRAMES - 1);
   localparam logic [WW-1:0] WDT_ONE = WW'(1);

   logic [WW-1:0] wdt_cnt;

   assign trip_now = armed && bnd && !cmd_valid &&
                     (wdt_cnt == WDT_TOP);

   // Trip is sticky until arm is released, forcing a full re-arm.
   always_ff @(posedge clk) begin
      if (rst) begin
         wdt_cnt  <= '0;
         wdt_trip <= 1'b0;
      end else begin
         if (cmd_valid || !armed)
            wdt_cnt <= '0;
         else if (bnd)
            wdt_cnt <= wdt_cnt + WDT_ONE;
         if (!arm)
            wdt_trip <= 1'b0;
         else if (trip_now)
            wdt_trip <= 1'b1;
      end
   end
`else
   assign trip_now = 1'b0;
   assign wdt_trip = 1'b0;
`endif

endmodule
